// File: rtl/aes128_encrypt_iter_if.sv
// Stream bundle for aes128_encrypt_iter.
//   Input side : in_valid/in_ready handshake carrying plaintext + key.
//   Output side: out_valid/out_ready handshake carrying ciphertext.
// master drives blocks in and consumes results; slave is the cipher core.
interface aes128_encrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid,
    output plaintext,
    output key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext
  );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock using 16 S-box lookups and a
// single 128-bit state register. Round keys come from an external key_expansion block that
// is driven from registered/decoded signals here and answers combinationally.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : in_valid/in_ready + plaintext/key in; out_valid/out_ready + ciphertext out
//   key_out       : latched cipher key, to key_expansion.key
//   round_out     : round index, to key_expansion.round
//   round_key_in  : key_expansion.op_key for round_out (same cycle)
//
// Byte order: column-major, column c = [127-32c -: 32], row 0 is the MSB byte of a column.
// Timing: accept edge, ADDKEY edge, 10 round edges -> out_valid 11 edges after accept.
module aes128_encrypt_iter #(
  parameter int unsigned NR = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  aes128_encrypt_iter_if.slave      bus,
  output logic [127:0]              key_out,
  output logic [3:0]                round_out,
  input  logic [127:0]              round_key_in
);

  if (NR != 10) begin : gen_nr_unsupported
    $error("aes128_encrypt_iter: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LastRound = 4'(NR);

  // Forward S-box; element [255] holds S(0x00), so S(x) = SboxTbl[~x].
  localparam logic [255:0][7:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StAddKey, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_q, key_d;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTbl[~x];
  endfunction

  // Multiply by 02 in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r of output column c takes row r of input column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // Round datapath
  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] round_mid;
  logic [127:0] round_final;

  for (genvar i = 0; i < 16; i++) begin : gen_sbox
    assign sub_bytes[8*i +: 8] = sbox(blk_q[8*i +: 8]);
  end

  assign shifted     = shift_rows(sub_bytes);
  assign round_mid   = mix_columns(shifted) ^ round_key_in;
  assign round_final = shifted ^ round_key_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    key_d   = key_q;
    unique case (state_q)
      StIdle: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          blk_d   = bus.plaintext;
          key_d   = bus.key;
          state_d = StAddKey;
        end
      end
      StAddKey: begin
        blk_d   = blk_q ^ round_key_in;
        rnd_d   = 4'd1;
        state_d = StRound;
      end
      StRound: begin
        if (rnd_q == LastRound) begin
          blk_d   = round_final;
          rnd_d   = 4'd0;
          state_d = StDone;
        end else begin
          blk_d = round_mid;
          rnd_d = rnd_q + 4'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only; no path from round_key_in back to round_out.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    round_out     = 4'd0;
    unique case (state_q)
      StIdle:   bus.in_ready  = 1'b1;
      StAddKey: round_out     = 4'd0;
      StRound:  round_out     = rnd_q;
      StDone:   bus.out_valid = 1'b1;
      default:  round_out     = 4'd0;
    endcase
  end

  assign bus.ciphertext = blk_q;
  assign key_out        = key_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: an independent key_expansion model feeds round keys,
// expected ciphertexts are queued on accept and checked when the core presents a result.
module tb_aes128_encrypt_iter;

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic [127:0] round_key_in;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  aes128_encrypt_iter_if bus_if ();

  aes128_encrypt_iter #(
    .NR(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .key_out      (key_out),
    .round_out    (round_out),
    .round_key_in (round_key_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- key_expansion reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(x) = affine(x^254), computed from first principles rather than a table.
  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] res, base, e;
    res  = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) res = gmul(res, base);
      base = gmul(base, base);
    end
    return res ^ rotl8(res, 1) ^ rotl8(res, 2) ^ rotl8(res, 3) ^ rotl8(res, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    w0   = k[127:96];
    w1   = k[95:64];
    w2   = k[63:32];
    w3   = k[31:0];
    rcon = 8'h01;
    for (int i = 1; i <= 15; i++) begin
      if (i <= int'(r)) begin
        t  = {sbox_m(w3[23:16]), sbox_m(w3[15:8]), sbox_m(w3[7:0]), sbox_m(w3[31:24])};
        t  = t ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        rcon = gmul(rcon, 8'h02);
      end
    end
    return {w0, w1, w2, w3};
  endfunction

  assign round_key_in = ref_round_key(key_out, round_out);

  // ---------------- stimulus helpers (no checking inside) ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] k, output bit ok);
    int n;
    n = 0;
    bus_if.in_valid  = 1'b1;
    bus_if.plaintext = pt;
    bus_if.key       = k;
    while (bus_if.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (bus_if.in_ready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; -1 if it never comes.
  task automatic wait_out(input int start, output int edges);
    int e;
    e     = start;
    edges = -1;
    while (edges < 0 && e < start + 40) begin
      @(posedge clk);
      @(negedge clk);
      e++;
      if (bus_if.out_valid === 1'b1) edges = e;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.plaintext = '0;
    bus_if.key       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready);
    end
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid);
    end
    checks++;
    if (bus_if.ciphertext !== 128'h0) begin
      failures++;
      $display("FAIL reset_ciphertext got=%h exp=0", bus_if.ciphertext);
    end
    checks++;
    if (key_out !== 128'h0) begin
      failures++;
      $display("FAIL reset_key_out got=%h exp=0", key_out);
    end
    checks++;
    if (round_out !== 4'd0) begin
      failures++;
      $display("FAIL reset_round_out got=%0d exp=0", round_out);
    end
  endtask

  task automatic test_fips_b;
    bit ok;
    int edges;
    send(PtB, KeyB, ok);
    exp_q.push_back(CtB);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fips_b_accept got=not_accepted exp=accepted");
    end
    wait_out(0, edges);
    checks++;
    if (edges != 11) begin
      failures++;
      $display("FAIL fips_b_latency got=%0d exp=11", edges);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.ciphertext !== CtB || bus_if.in_ready !== 1'b0)
      begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b rdy=%b ct=%h exp v=1 rdy=0 ct=%h",
                 i, bus_if.out_valid, bus_if.in_ready, bus_if.ciphertext, CtB);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL fips_b_ct got=%h exp=<none queued>", bus_if.ciphertext);
    end else begin
      exp = exp_q.pop_front();
      if (bus_if.ciphertext !== exp) begin
        failures++;
        $display("FAIL fips_b_ct got=%h exp=%h", bus_if.ciphertext, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release got v=%b rdy=%b exp v=0 rdy=1",
               bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_fips_c;
    bit ok;
    int edges;
    logic [127:0] exp;
    send(PtC, KeyC, ok);
    exp_q.push_back(CtC);
    wait_out(0, edges);
    checks++;
    if (edges != 11) begin
      failures++;
      $display("FAIL fips_c_latency got=%0d exp=11", edges);
    end
    bus_if.out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL fips_c_ct got=%h exp=<none queued>", bus_if.ciphertext);
    end else begin
      exp = exp_q.pop_front();
      if (bus_if.ciphertext !== exp) begin
        failures++;
        $display("FAIL fips_c_ct got=%h exp=%h", bus_if.ciphertext, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fips_c_out_valid_drop got=%b exp=0", bus_if.out_valid);
    end
  endtask

  task automatic test_busy_drop;
    bit ok;
    int edges;
    int stray;
    logic [127:0] exp;
    send(PtB, KeyB, ok);
    exp_q.push_back(CtB);
    for (int e = 1; e <= 8; e++) begin
      bus_if.in_valid  = (e >= 3 && e <= 8);
      bus_if.plaintext = PtC;
      bus_if.key       = KeyC;
      if (e >= 3) begin
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_in_ready edge=%0d got=%b exp=0", e, bus_if.in_ready);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    wait_out(8, edges);
    checks++;
    if (edges != 11) begin
      failures++;
      $display("FAIL busy_latency got=%0d exp=11", edges);
    end
    bus_if.out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL busy_ct got=%h exp=<none queued>", bus_if.ciphertext);
    end else begin
      exp = exp_q.pop_front();
      if (bus_if.ciphertext !== exp) begin
        failures++;
        $display("FAIL busy_ct got=%h exp=%h", bus_if.ciphertext, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus_if.out_valid === 1'b1) stray++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL busy_no_second_block got=%0d valid cycles exp=0", stray);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    int stray;
    int edges;
    logic [127:0] exp;
    send(PtB, KeyB, ok);
    n = 0;
    while (round_out !== 4'd5 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++;
    if (round_out !== 4'd5) begin
      failures++;
      $display("FAIL rstmid_reach_round5 got=%0d exp=5", round_out);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || round_out !== 4'd0) begin
      failures++;
      $display("FAIL rstmid_state got v=%b rdy=%b rnd=%0d exp v=0 rdy=1 rnd=0",
               bus_if.out_valid, bus_if.in_ready, round_out);
    end
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus_if.out_valid === 1'b1) stray++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid_dropped got=%0d valid cycles exp=0", stray);
    end
    send(PtC, KeyC, ok);
    exp_q.push_back(CtC);
    wait_out(0, edges);
    bus_if.out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL rstmid_ct got=%h exp=<none queued>", bus_if.ciphertext);
    end else begin
      exp = exp_q.pop_front();
      if (edges < 0 || bus_if.ciphertext !== exp) begin
        failures++;
        $display("FAIL rstmid_ct got=%h (edges=%0d) exp=%h", bus_if.ciphertext, edges, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int acc;
    int outs;
    int acc_edge[2];
    bit take;
    logic [127:0] exp;
    cyc  = 0;
    acc  = 0;
    outs = 0;
    acc_edge[0] = -100;
    acc_edge[1] = -100;
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.plaintext = PtB;
    bus_if.key       = KeyB;
    while (outs < 2 && cyc < 80) begin
      if (bus_if.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_ct%0d got=%h exp=<none queued>", outs, bus_if.ciphertext);
        end else begin
          exp = exp_q.pop_front();
          if (bus_if.ciphertext !== exp) begin
            failures++;
            $display("FAIL b2b_ct%0d got=%h exp=%h", outs, bus_if.ciphertext, exp);
          end
        end
        outs++;
      end
      take = (bus_if.in_valid === 1'b1) && (bus_if.in_ready === 1'b1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (take && acc < 2) begin
        acc_edge[acc] = cyc;
        exp_q.push_back((acc == 0) ? CtB : CtC);
        acc++;
        if (acc == 1) begin
          bus_if.plaintext = PtC;
          bus_if.key       = KeyC;
        end else begin
          bus_if.in_valid = 1'b0;
        end
      end
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    checks++;
    if (outs != 2) begin
      failures++;
      $display("FAIL b2b_outputs got=%0d exp=2", outs);
    end
    checks++;
    if (acc_edge[1] - acc_edge[0] != 13) begin
      failures++;
      $display("FAIL b2b_accept_gap got=%0d exp=13", acc_edge[1] - acc_edge[0]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_backpressure();
    test_fips_c();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
